mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester SRAM/ROM access arbiter with lock and hold limit
//
// Purpose:
//   Shares one memory port between requester 0 (core) and requester 1
//   (loader). Ownership is held in a registered FSM (IDLE/OWN0/OWN1). The
//   owner is granted combinationally whenever it requests. A lock lets the
//   owner keep the port across back-to-back accesses, up to MAX_HOLD grants
//   while the other side waits.
//   Reads return one cycle after issue on the shared rdata bus.
//
// Optional feature:
//   MEM_ARB_ERR_EN - when defined, a granted ROM write sets the sticky err
//   flag. When undefined, err is tied to 0. In both builds the ROM write is
//   dropped.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   req0/1, we0/1, sel0/1  request, write (1) / read (0), target ROM (1) / SRAM (0)
//   lock0/1                keep ownership across back-to-back accesses
//   addr0/1, wdata0/1      per-requester address and write data
//   gnt0/1                 access accepted this cycle
//   rvalid0/1, rdata       read return, one cycle after the grant
//   err                    sticky ROM-write error
//   csb[1:0]               active-low chip selects, [1] ROM, [0] SRAM
//   web                    active-low SRAM write enable
//   addr, dout             memory address and SRAM write data
//   dinw, dinx             ROM / SRAM read data, valid one cycle after issue
module mem_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              sel0,
  input  logic              sel1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [1:0]        csb,
  output logic              web,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  input  logic [DATA_W-1:0] dinw,
  input  logic [DATA_W-1:0] dinx
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              rsel_q, rsel_d;

  // Request presented by whichever side is granted this cycle.
  logic              gnt_any;
  logic              g_we;
  logic              g_sel;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  // hold_cnt already includes a grant made this cycle, so the owner gets
  // exactly MAX_HOLD grants before it must yield to a waiting requester.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if ((!req0 || !lock0 || (hold_cnt == HOLD_MAX)) && req1) begin
          state_d = ST_OWN1;
        end else if (!req0) begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if ((!req1 || !lock1 || (hold_cnt == HOLD_MAX)) && req0) begin
          state_d = ST_OWN0;
        end else if (!req1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: output logic (grants follow the owner's request combinationally)
  // ------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      ST_OWN0: gnt0 = req0;
      ST_OWN1: gnt1 = req1;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Granted-request mux
  // ------------------------------------------------------------------
  always_comb begin
    gnt_any = gnt0 | gnt1;
    g_we    = gnt1 ? we1    : we0;
    g_sel   = gnt1 ? sel1   : sel0;
    g_addr  = gnt1 ? addr1  : addr0;
    g_wdata = gnt1 ? wdata1 : wdata0;
  end

  // ------------------------------------------------------------------
  // Memory-side drive
  // ------------------------------------------------------------------
  // addr/dout follow the granted request and otherwise hold the last
  // driven value. A ROM write keeps both selects high and is dropped.
  always_comb begin
    csb    = 2'b11;
    web    = 1'b1;
    addr_d = addr_q;
    dout_d = dout_q;
    if (gnt_any) begin
      addr_d = g_addr;
      dout_d = g_wdata;
      if (!(g_we && g_sel)) begin
        csb = g_sel ? 2'b01 : 2'b10;
        web = ~(g_we & ~g_sel);
      end
    end
    addr = addr_d;
    dout = dout_d;
  end

  // ------------------------------------------------------------------
  // Hold counter and read-return tracking
  // ------------------------------------------------------------------
  always_comb begin
    hold_cnt = hold_q;
    if (gnt_any && (hold_q != HOLD_MAX)) begin
      hold_cnt = hold_q + HOLD_W'(1);
    end
    // Any change of ownership (including to IDLE) restarts the count.
    hold_d = (state_d != state_q) ? '0 : hold_cnt;

    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rsel_d    = (gnt_any && !g_we) ? g_sel : rsel_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q    <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rsel_q    <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rsel_q    <= rsel_d;
    end
  end

  // rdata is forced to zero outside a return so reset and idle cycles read 0.
  always_comb begin
    rvalid0 = rvalid0_q;
    rvalid1 = rvalid1_q;
    rdata   = '0;
    if (rvalid0_q || rvalid1_q) begin
      rdata = rsel_q ? dinw : dinx;
    end
  end

  // ------------------------------------------------------------------
  // Sticky ROM-write error
  // ------------------------------------------------------------------
`ifdef MEM_ARB_ERR_EN
  logic err_q, err_d;
  logic rom_wr;

  always_comb begin
    rom_wr = gnt_any & g_we & g_sel;
    err_d  = err_q | rom_wr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 8;

`ifdef MEM_ARB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, we0, we1, sel0, sel1, lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, err, web;
  logic [DATA_W-1:0] rdata, dout, dinw, dinx;
  logic [1:0]        csb;
  logic [ADDR_W-1:0] addr;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .sel0(sel0), .sel1(sel1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err), .csb(csb), .web(web),
    .addr(addr), .dout(dout), .dinw(dinw), .dinx(dinx)
  );

  always #5 clk = ~clk;

  // Synchronous memory models: SRAM 64 words, ROM content = addr*3+1.
  logic [DATA_W-1:0] sram [0:63];

  initial begin
    for (int i = 0; i < 64; i++) sram[i] <= 8'h00;
    sram[5] <= 8'h3C;
  end

  always @(posedge clk) begin
    if (!csb[0]) begin
      if (!web) sram[addr[5:0]] <= dout;
      else      dinx <= sram[addr[5:0]];
    end
    if (!csb[1]) dinw <= 8'(addr * 3 + 1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt0"},    gnt0,    1'b0);
    chk({tag, "_gnt1"},    gnt1,    1'b0);
    chk({tag, "_rvalid0"}, rvalid0, 1'b0);
    chk({tag, "_rvalid1"}, rvalid1, 1'b0);
    chk({tag, "_rdata"},   rdata,   8'h00);
    chk({tag, "_err"},     err,     1'b0);
    chk({tag, "_csb"},     csb,     2'b11);
    chk({tag, "_web"},     web,     1'b1);
    chk({tag, "_addr"},    addr,    7'd0);
    chk({tag, "_dout"},    dout,    8'h00);
  endtask

  initial begin
    rst = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; sel0 = 0; sel1 = 0;
    lock0 = 0; lock1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state
    sample();
    sample();
    chk_reset_outputs("rst");
    next_cycle();
    rst = 1'b1;

    // SRAM read by requester 0: addr 5 holds 3C
    req0 = 1; we0 = 0; sel0 = 0; addr0 = 7'd5;
    sample();
    chk("r0_idle_gnt0", gnt0, 1'b0);
    chk("r0_idle_csb",  csb,  2'b11);
    next_cycle();
    sample();
    chk("r0_gnt0",  gnt0, 1'b1);
    chk("r0_gnt1",  gnt1, 1'b0);
    chk("r0_csb",   csb,  2'b10);
    chk("r0_web",   web,  1'b1);
    chk("r0_addr",  addr, 7'd5);
    next_cycle();
    req0 = 0;
    sample();
    chk("r0_rvalid0",    rvalid0, 1'b1);
    chk("r0_rdata",      rdata,   8'h3C);
    chk("r0_rvalid1",    rvalid1, 1'b0);
    chk("r0_addr_hold",  addr,    7'd5);
    chk("r0_csb_nogrant", csb,    2'b11);
    next_cycle();
    sample();
    chk("r0_rvalid_once", rvalid0, 1'b0);
    next_cycle();

    // Requester 1 writes A5 to SRAM addr 10, then reads it back
    req1 = 1; we1 = 1; sel1 = 0; addr1 = 7'd10; wdata1 = 8'hA5;
    sample();
    chk("w1_idle_gnt1", gnt1, 1'b0);
    next_cycle();
    sample();
    chk("w1_gnt1", gnt1, 1'b1);
    chk("w1_gnt0", gnt0, 1'b0);
    chk("w1_csb",  csb,  2'b10);
    chk("w1_web",  web,  1'b0);
    chk("w1_addr", addr, 7'd10);
    chk("w1_dout", dout, 8'hA5);
    next_cycle();
    we1 = 0;
    sample();
    chk("r1_gnt1",          gnt1,    1'b1);
    chk("r1_web",           web,     1'b1);
    chk("w1_no_rvalid",     rvalid1, 1'b0);
    next_cycle();
    req1 = 0;
    sample();
    chk("r1_rvalid1", rvalid1, 1'b1);
    chk("r1_rvalid0", rvalid0, 1'b0);
    chk("r1_rdata",   rdata,   8'hA5);
    next_cycle();

    // Both requesting, locks low: grants alternate 0,1,0,1
    req0 = 1; we0 = 0; sel0 = 0; addr0 = 7'd1;
    req1 = 1; we1 = 0; sel1 = 0; addr1 = 7'd2;
    sample();
    chk("rr_idle_gnt0", gnt0, 1'b0);
    chk("rr_idle_gnt1", gnt1, 1'b0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2) == 0);
      chk($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2) == 1);
      chk($sformatf("rr_csb_%0d", i),  csb,  2'b10);
      if (i > 0) chk($sformatf("rr_rvalid0_%0d", i), rvalid0, (i % 2) == 1);
      next_cycle();
    end
    req0 = 0; req1 = 0;
    next_cycle();

    // lock0 held with requester 1 waiting: exactly MAX_HOLD grants to 0
    req0 = 1; lock0 = 1; we0 = 0; sel0 = 0; addr0 = 7'd3;
    req1 = 1; we1 = 0; sel1 = 0; addr1 = 7'd4;
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      sample();
      chk($sformatf("lk_gnt0_%0d", i), gnt0, 1'b1);
      chk($sformatf("lk_gnt1_%0d", i), gnt1, 1'b0);
      next_cycle();
    end
    sample();
    chk("lk_after_gnt0", gnt0, 1'b0);
    chk("lk_after_gnt1", gnt1, 1'b1);
    next_cycle();
    req0 = 0; req1 = 0; lock0 = 0;
    next_cycle();

    // ROM read: addr 3 returns 3*3+1 = 0A
    req0 = 1; we0 = 0; sel0 = 1; addr0 = 7'd3;
    next_cycle();
    sample();
    chk("rom_rd_gnt0", gnt0, 1'b1);
    chk("rom_rd_csb",  csb,  2'b01);
    next_cycle();
    req0 = 0;
    sample();
    chk("rom_rd_rvalid0", rvalid0, 1'b1);
    chk("rom_rd_rdata",   rdata,   8'h0A);
    next_cycle();

    // ROM write to addr 64: granted, dropped, err per build
    req0 = 1; we0 = 1; sel0 = 1; addr0 = 7'd64; wdata0 = 8'h77;
    sample();
    chk("rom_wr_err_before", err, 1'b0);
    next_cycle();
    sample();
    chk("rom_wr_gnt0", gnt0, 1'b1);
    chk("rom_wr_csb",  csb,  2'b11);
    chk("rom_wr_web",  web,  1'b1);
    chk("rom_wr_addr", addr, 7'd64);
    chk("rom_wr_dout", dout, 8'h77);
    next_cycle();
    req0 = 0;
    sample();
    chk("rom_wr_err",    err,     ERR_EXP);
    chk("rom_wr_rvalid", rvalid0, 1'b0);
    next_cycle();
    sample();
    chk("rom_wr_err_sticky", err, ERR_EXP);
    next_cycle();

    // Reset pulled low the cycle after a read grant aborts the read
    req0 = 1; we0 = 0; sel0 = 0; addr0 = 7'd5;
    next_cycle();
    sample();
    chk("ab_gnt0", gnt0, 1'b1);
    next_cycle();
    rst = 1'b0;
    req0 = 0;
    sample();
    chk_reset_outputs("ab_rst");
    next_cycle();
    rst = 1'b1;
    sample();
    chk("ab_rvalid0_rel",  rvalid0, 1'b0);
    chk("ab_gnt0_rel",     gnt0,    1'b0);
    next_cycle();
    sample();
    chk("ab_rvalid0_rel2", rvalid0, 1'b0);
    chk("ab_csb_rel2",     csb,     2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
